// File: rtl/mem_port_router.sv
// mem_port_router: round-robin arbiter of NUM_CH requestors onto one memory port,
// with per-channel address counters and an in-order tag FIFO for read responses.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

module mem_port_router #(
    parameter int                NUM_CH  = 3,
    parameter int                ADDR_W  = `MEM_ADDR_SIZE,
    parameter int                DATA_W  = `MEM_BANDWIDTH*8,
    parameter int                MAX_OUT = 16,
    parameter logic [NUM_CH-1:0] WR_MASK = 3'b100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_start_addr,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]              ch_ack,
    output logic [NUM_CH-1:0]              ch_rvalid,
    output logic [DATA_W-1:0]              ch_rdata,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_write_data,
    output logic                           mem_read_valid,
    output logic                           mem_write_valid,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           mem_valid,
    output logic [$clog2(MAX_OUT):0]       outstanding,
    output logic                           armed,
    output logic                           err_rsp
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(MAX_OUT);

    logic                          armed_q;
    logic [PW-1:0]                 ptr_q;
    logic [PW-1:0]                 ptr_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_q;
    logic [MAX_OUT-1:0][PW-1:0]    tag_q;
    logic [AW-1:0]                 wr_q;
    logic [AW-1:0]                 rd_q;
    logic [AW:0]                   cnt_q;
    logic                          err_q;

    logic [NUM_CH-1:0] elig;
    logic              gnt_vld;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_wr;
    logic [PW:0]       j;
    logic              push;
    logic              pop;
    logic              stray;

    // Read eligibility uses the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            elig[k] = armed_q && !start && ch_req[k]
                      && (WR_MASK[k] || (cnt_q < (AW+1)'(MAX_OUT)));
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = {1'b0, ptr_q} + (PW+1)'(i);
            if (j >= (PW+1)'(NUM_CH)) begin
                j = j - (PW+1)'(NUM_CH);
            end
            if (!gnt_vld && elig[j[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = j[PW-1:0];
            end
        end
    end

    assign gnt_wr = WR_MASK[gnt_idx];
    assign ptr_d  = (gnt_idx == PW'(NUM_CH-1)) ? '0 : gnt_idx + PW'(1);

    always_comb begin
        ch_ack          = '0;
        mem_addr        = '0;
        mem_write_data  = '0;
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        if (gnt_vld) begin
            ch_ack[gnt_idx] = 1'b1;
            mem_addr        = addr_q[gnt_idx];
            mem_write_valid = gnt_wr;
            mem_read_valid  = !gnt_wr;
            if (gnt_wr) begin
                mem_write_data = ch_wdata[gnt_idx];
            end
        end
    end

    assign push  = mem_read_valid;
    assign pop   = armed_q && mem_valid && (cnt_q != '0);
    assign stray = armed_q && mem_valid && (cnt_q == '0);

    always_comb begin
        ch_rvalid = '0;
        if (pop) begin
            ch_rvalid[tag_q[rd_q]] = 1'b1;
        end
    end

    assign ch_rdata    = armed_q ? mem_data : '0;
    assign outstanding = cnt_q;
    assign armed       = armed_q;
    assign err_rsp     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            ptr_q   <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (start) begin
            armed_q <= 1'b1;
            ptr_q   <= '0;
            addr_q  <= ch_start_addr;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (gnt_vld) begin
                addr_q[gnt_idx] <= addr_q[gnt_idx] + ADDR_W'(1);
                ptr_q           <= ptr_d;
            end
            if (push) begin
                tag_q[wr_q] <= gnt_idx;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_router.sv
// Directed bench for mem_port_router: vector table for arbitration and
// response routing, hand sequences for stall, stray response, wrap and reset.
module tb_mem_port_router;

    localparam int NC = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [NC-1:0][AW-1:0] sa;
    logic [NC-1:0][3:0] sa4;
    logic [NC-1:0] req = '0;
    logic [NC-1:0][DW-1:0] wdata;
    logic [DW-1:0] mdata;
    logic mvalid = 1'b0;

    logic [NC-1:0] ack, rvl;
    logic [DW-1:0] rdata, mwdata;
    logic [AW-1:0] maddr;
    logic mrv, mwv, armed, err;
    logic [4:0] outst;

    logic [NC-1:0] ack4, rvl4;
    logic [DW-1:0] rdata4, mwdata4;
    logic [3:0] maddr4;
    logic mrv4, mwv4, armed4, err4;
    logic [4:0] outst4;

    mem_port_router #(
        .NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW),
        .MAX_OUT(MO), .WR_MASK(3'b100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ch_start_addr(sa), .ch_req(req), .ch_wdata(wdata),
        .ch_ack(ack), .ch_rvalid(rvl), .ch_rdata(rdata),
        .mem_addr(maddr), .mem_write_data(mwdata),
        .mem_read_valid(mrv), .mem_write_valid(mwv),
        .mem_data(mdata), .mem_valid(mvalid),
        .outstanding(outst), .armed(armed), .err_rsp(err)
    );

    mem_port_router #(
        .NUM_CH(NC), .ADDR_W(4), .DATA_W(DW),
        .MAX_OUT(MO), .WR_MASK(3'b100)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ch_start_addr(sa4), .ch_req(req), .ch_wdata(wdata),
        .ch_ack(ack4), .ch_rvalid(rvl4), .ch_rdata(rdata4),
        .mem_addr(maddr4), .mem_write_data(mwdata4),
        .mem_read_valid(mrv4), .mem_write_valid(mwv4),
        .mem_data(mdata), .mem_valid(mvalid),
        .outstanding(outst4), .armed(armed4), .err_rsp(err4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] rq, input logic mv);
        start  = st;
        req    = rq;
        mvalid = mv;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       st;
        logic [2:0] req;
        logic       mv;
        logic [2:0] ack;
        logic [15:0] addr;
        logic       rv;
        logic       wv;
        logic [2:0] rvl;
        logic [4:0] out;
    } vec_t;

    function automatic vec_t mk(logic st, logic [2:0] rq, logic mv,
                                logic [2:0] a, logic [15:0] ad, logic r,
                                logic w, logic [2:0] rv, logic [4:0] o);
        vec_t v;
        v = '{st, rq, mv, a, ad, r, w, rv, o};
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int g;
        logic [DW-1:0] wexp;

        // ch0 alone, then drain its four reads
        tbl[0]  = mk(0, 3'b001, 0, 3'b001, 16'h0010, 1, 0, 3'b000, 5'd0);
        tbl[1]  = mk(0, 3'b001, 0, 3'b001, 16'h0011, 1, 0, 3'b000, 5'd1);
        tbl[2]  = mk(0, 3'b001, 0, 3'b001, 16'h0012, 1, 0, 3'b000, 5'd2);
        tbl[3]  = mk(0, 3'b001, 0, 3'b001, 16'h0013, 1, 0, 3'b000, 5'd3);
        tbl[4]  = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b001, 5'd4);
        tbl[5]  = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b001, 5'd3);
        tbl[6]  = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b001, 5'd2);
        tbl[7]  = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b001, 5'd1);
        // restart, then all three channels requesting
        tbl[8]  = mk(1, 3'b111, 0, 3'b000, 16'h0000, 0, 0, 3'b000, 5'd0);
        tbl[9]  = mk(0, 3'b111, 0, 3'b001, 16'h0010, 1, 0, 3'b000, 5'd0);
        tbl[10] = mk(0, 3'b111, 0, 3'b010, 16'h0200, 1, 0, 3'b000, 5'd1);
        tbl[11] = mk(0, 3'b111, 0, 3'b100, 16'h3000, 0, 1, 3'b000, 5'd2);
        tbl[12] = mk(0, 3'b111, 0, 3'b001, 16'h0011, 1, 0, 3'b000, 5'd2);
        tbl[13] = mk(0, 3'b111, 0, 3'b010, 16'h0201, 1, 0, 3'b000, 5'd3);
        tbl[14] = mk(0, 3'b111, 0, 3'b100, 16'h3001, 0, 1, 3'b000, 5'd4);
        // responses routed by issue order while grants continue
        tbl[15] = mk(0, 3'b111, 1, 3'b001, 16'h0012, 1, 0, 3'b001, 5'd4);
        tbl[16] = mk(0, 3'b111, 1, 3'b010, 16'h0202, 1, 0, 3'b010, 5'd4);
        tbl[17] = mk(0, 3'b111, 1, 3'b100, 16'h3002, 0, 1, 3'b001, 5'd4);
        tbl[18] = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b010, 5'd3);
        tbl[19] = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b001, 5'd2);
        tbl[20] = mk(0, 3'b000, 1, 3'b000, 16'h0000, 0, 0, 3'b010, 5'd1);
        tbl[21] = mk(0, 3'b000, 0, 3'b000, 16'h0000, 0, 0, 3'b000, 5'd0);

        sa[0] = 16'h0010;
        sa[1] = 16'h0200;
        sa[2] = 16'h3000;
        sa4[0] = 4'hE;
        sa4[1] = 4'h1;
        sa4[2] = 4'h2;
        wdata = '0;
        mdata = 32'h1234_5678;

        // reset state: everything 0 even with requests and responses present
        req = 3'b111;
        mvalid = 1'b1;
        #12;
        chk("rst ack", ack, 3'b000);
        chk("rst armed", armed, 1'b0);
        chk("rst out", outst, 5'd0);
        chk("rst err", err, 1'b0);
        chk("rst rvalid", rvl, 3'b000);
        chk("rst addr", maddr, 16'h0);
        chk("rst rdata", rdata, 32'h0);
        rst_n = 1'b1;
        nxt();
        @(negedge clk);
        chk("unarmed ack", ack, 3'b000);
        chk("unarmed err", err, 1'b0);
        chk("unarmed rv", mrv, 1'b0);
        nxt();

        drive(1, 3'b000, 0);
        chk("start ack", ack, 3'b000);
        chk("start armed", armed, 1'b0);
        nxt();

        for (int i = 0; i < 22; i++) begin
            wdata[2] = {16'hA5A5, 16'(i)};
            mdata = 32'hD000_0000 + i;
            drive(tbl[i].st, tbl[i].req, tbl[i].mv);
            wexp = tbl[i].wv ? {16'hA5A5, 16'(i)} : 32'h0;
            chk($sformatf("v%0d ack", i), ack, tbl[i].ack);
            chk($sformatf("v%0d addr", i), maddr, tbl[i].addr);
            chk($sformatf("v%0d rv", i), mrv, tbl[i].rv);
            chk($sformatf("v%0d wv", i), mwv, tbl[i].wv);
            chk($sformatf("v%0d wdata", i), mwdata, wexp);
            chk($sformatf("v%0d rvalid", i), rvl, tbl[i].rvl);
            chk($sformatf("v%0d rdata", i), rdata, 32'hD000_0000 + i);
            chk($sformatf("v%0d out", i), outst, tbl[i].out);
            chk($sformatf("v%0d armed", i), armed, 1'b1);
            chk($sformatf("v%0d err", i), err, 1'b0);
            nxt();
        end

        // ch1 reads against a stalled memory: capped at MAX_OUT
        g = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 3'b010, 0);
            if (ack == 3'b010) g++;
            nxt();
        end
        chk("stall grants", g, 16);
        for (int i = 0; i < 2; i++) begin
            drive(0, 3'b110, 0);
            chk("stall out", outst, 5'd16);
            chk("stall ack", ack, 3'b100);
            chk("stall wv", mwv, 1'b1);
            nxt();
        end
        drive(0, 3'b010, 1);
        chk("pop cycle ack", ack, 3'b000);
        chk("pop cycle rvalid", rvl, 3'b010);
        nxt();
        drive(0, 3'b010, 0);
        chk("regrant ack", ack, 3'b010);
        chk("regrant out", outst, 5'd15);
        chk("regrant addr", maddr, 16'h0213);
        nxt();
        g = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 3'b000, 1);
            if (rvl == 3'b010) g++;
            nxt();
        end
        chk("drain rsp", g, 16);
        drive(0, 3'b000, 0);
        chk("drain out", outst, 5'd0);
        chk("drain err", err, 1'b0);
        nxt();

        // response with nothing outstanding
        drive(0, 3'b000, 1);
        chk("stray rvalid", rvl, 3'b000);
        nxt();
        drive(0, 3'b000, 0);
        chk("stray err", err, 1'b1);
        nxt();
        nxt();
        nxt();
        drive(0, 3'b000, 0);
        chk("err sticky", err, 1'b1);
        chk("err out", outst, 5'd0);
        nxt();
        drive(1, 3'b000, 0);
        nxt();
        drive(0, 3'b000, 0);
        chk("err cleared", err, 1'b0);
        nxt();

        // 4-bit address wrap
        drive(0, 3'b001, 0);
        chk("wrap0 ack", ack4, 3'b001);
        chk("wrap0 addr", maddr4, 4'hE);
        nxt();
        drive(0, 3'b001, 0);
        chk("wrap1 addr", maddr4, 4'hF);
        nxt();
        drive(0, 3'b001, 0);
        chk("wrap2 addr", maddr4, 4'h0);
        nxt();

        // async reset mid-burst
        drive(0, 3'b001, 0);
        chk("pre-rst ack", ack, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("mid-rst ack", ack, 3'b000);
        chk("mid-rst armed", armed, 1'b0);
        chk("mid-rst ack4", ack4, 3'b000);
        chk("mid-rst out", outst, 5'd0);
        nxt();
        rst_n = 1'b1;
        drive(0, 3'b001, 1);
        chk("post-rst ack", ack, 3'b000);
        chk("post-rst rvalid", rvl, 3'b000);
        nxt();
        drive(0, 3'b001, 0);
        chk("post-rst err", err, 1'b0);
        chk("post-rst armed", armed, 1'b0);
        nxt();
        drive(1, 3'b001, 0);
        chk("restart ack", ack, 3'b000);
        nxt();
        drive(0, 3'b001, 0);
        chk("rearm ack", ack, 3'b001);
        chk("rearm addr", maddr, 16'h0010);
        chk("rearm addr4", maddr4, 4'hE);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_router.md
# mem_port_router

Parametrised successor of the layer controller's memory-arbitration section. It arbitrates `NUM_CH` requestor channels (decompressor, weight buffer, compressor, and future buffers) onto the single TB memory port using round-robin selection. It keeps a per-channel auto-incrementing address and tracks outstanding reads in an in-order tag FIFO, so `mem_valid` responses reach the channel that issued them rather than the channel currently granted. It sits between the controller FSM and the memory port.

## Interface
Parameters:
- `NUM_CH`, 3, number of requestor channels (2..8)
- `ADDR_W`, `` `MEM_ADDR_SIZE ``, address width
- `DATA_W`, `` `MEM_BANDWIDTH*8 ``, data width
- `MAX_OUT`, 16, maximum outstanding reads (power of 2, ≥2)
- `WR_MASK`, 3'b100, `NUM_CH` bits; bit k=1 makes channel k a write channel, 0 a read channel

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  synchronous layer start; loads addresses and flushes state
- `ch_start_addr`  in  `[NUM_CH][ADDR_W]`  per-channel start address, sampled on `start`
- `ch_req`  in  `NUM_CH`  per-channel request, level
- `ch_wdata`  in  `[NUM_CH][DATA_W]`  write data; used by write channels only
- `ch_ack`  out  `NUM_CH`  one-hot grant in the same cycle as the request
- `ch_rvalid`  out  `NUM_CH`  one-hot read-response strobe
- `ch_rdata`  out  `DATA_W`  read data, `mem_data` passthrough
- `mem_addr`  out  `ADDR_W`  address of the granted channel
- `mem_write_data`  out  `DATA_W`  `ch_wdata` of the granted write channel
- `mem_read_valid`  out  1  grant to a read channel
- `mem_write_valid`  out  1  grant to a write channel
- `mem_data`  in  `DATA_W`  memory read data
- `mem_valid`  in  1  memory read response
- `outstanding`  out  `$clog2(MAX_OUT)+1`  reads in flight
- `armed`  out  1  set by the first `start`
- `err_rsp`  out  1  sticky flag: response arrived with no read outstanding

## Operation
- Reset: `armed`=0, round-robin pointer=0, all address counters=0, tag FIFO empty, `outstanding`=0, `err_rsp`=0.
- While `armed`=0, all outputs are 0, including `ch_ack`.
- `start`:
  - next cycle: `armed`=1, each address counter = `ch_start_addr[k]`, FIFO flushed, `outstanding`=0, `err_rsp`=0, pointer=0.
  - no grant is issued in the `start` cycle.
- Eligibility:
  - write channel k is eligible when `ch_req[k]`.
  - read channel k is eligible when `ch_req[k]` and `outstanding < MAX_OUT`, evaluated before any same-cycle pop. There is no full-bypass.
- Arbitration:
  - Among eligible channels, grant the first index ≥ pointer, wrapping modulo `NUM_CH`.
  - After a grant to k, pointer = (k+1) mod `NUM_CH`. Pointer is unchanged when nothing is granted.
  - At most one grant per cycle.
- On a grant to k:
  - `ch_ack[k]`=1, `mem_addr` = addr[k].
  - addr[k] increments next cycle, wrapping at 2^`ADDR_W`.
  - Write channel: `mem_write_valid`=1, `mem_write_data`=`ch_wdata[k]`.
  - Read channel: `mem_read_valid`=1 and k is pushed into the tag FIFO.
- Responses:
  - Memory returns reads in order, at least 1 cycle after issue.
  - On `mem_valid` with FIFO non-empty: `ch_rvalid[head]`=1 combinationally, head pops.
  - On `mem_valid` with FIFO empty: no `ch_rvalid`, data dropped, `err_rsp` set.
- Simultaneous push and pop: `outstanding` is unchanged and both operations complete.
- Idle outputs: when nothing is granted, `mem_addr` and `mem_write_data` are 0.

## Timing
- Grant, `ch_ack`, `mem_addr`, `mem_*_valid`: combinational from `ch_req` and registered state, 0-cycle latency.
- Address counter, pointer, FIFO, `outstanding`: update on the clock edge after the grant.
- `ch_rvalid` / `ch_rdata`: combinational from `mem_valid` / `mem_data` and the FIFO head.
- Throughput: one grant per cycle sustained. A single requesting channel is granted every cycle.
- Async reset mid-operation: all state clears immediately; in-flight responses arriving after reset but before `start` are ignored (`armed`=0, no `err_rsp`).
- `start` while reads are in flight: those responses are treated as unexpected and set `err_rsp`.

## Test plan
- Reset then `start` with start addrs {0x10, 0x200, 0x3000}, only ch0 requesting for 4 cycles -> `ch_ack[0]` every cycle, `mem_addr` 0x10,0x11,0x12,0x13, `mem_read_valid`=1.
- All 3 channels requesting continuously for 6 cycles -> grant order 0,1,2,0,1,2; ch2 cycles show `mem_write_valid`=1 with `mem_write_data`=`ch_wdata[2]`.
- ch0 and ch1 interleaved reads, memory returns with 3-cycle latency -> `ch_rvalid` order 0,1,0,1 matching issue order, even while ch2 writes are granted in the same cycles.
- ch1 reads with memory stalled -> exactly 16 grants, `outstanding`=16, ch1 blocked while ch2 writes continue; one `mem_valid` -> next cycle ch1 is granted again.
- `mem_valid` pulse with no reads outstanding -> no `ch_rvalid`, `err_rsp`=1 and it stays 1 until the next `start`.
- Address wrap with `ADDR_W`=4, start addr 0xE, 3 grants -> 0xE, 0xF, 0x0; `rst_n` low mid-burst -> `ch_ack`=0 and `armed`=0 until the next `start`.
